// File: rtl/fa_multiss.sv
// Full-adder cell: one bit of sum and carry from three input bits.
// Latency: combinational, zero cycles.
// Backpressure: none.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// Unsigned WIDTH x WIDTH array multiplier with a registered 2*WIDTH-bit product.
// Latency: one cycle from operands at a clk edge to resu.
// Backpressure: none; a new operand pair is accepted on every edge.
module fa_multiss #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     mulcado,
    input  logic [WIDTH-1:0]     multi,
    output logic [2*WIDTH-1:0]   resu
);
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] resu_d;
    logic [2*WIDTH-1:0] resu_q;

    for (genvar i = 0; i < WIDTH; i++) begin : row_g
        logic [WIDTH-1:0] s;
        logic             co;

        if (i == 0) begin : first_g
            // The first row passes its partial products straight through.
            assign s  = mulcado & {WIDTH{multi[0]}};
            assign co = 1'b0;
        end else begin : add_g
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic [WIDTH:0]   c;

            // The previous row is shifted down one bit, and its carry-out fills the MSB.
            assign a    = {row_g[i-1].co, row_g[i-1].s[WIDTH-1:1]};
            assign b    = mulcado & {WIDTH{multi[i]}};
            assign c[0] = 1'b0;

            for (genvar j = 0; j < WIDTH; j++) begin : cell_g
                fa_cell u_fa (
                    .a  (a[j]),
                    .b  (b[j]),
                    .ci (c[j]),
                    .s  (s[j]),
                    .co (c[j+1])
                );
            end

            assign co = c[WIDTH];
        end

        assign prod[i] = s[0];
    end

    assign prod[2*WIDTH-1:WIDTH] = {row_g[WIDTH-1].co, row_g[WIDTH-1].s[WIDTH-1:1]};

    always_comb begin
        resu_d = prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resu_q <= '0;
        end else begin
            resu_q <= resu_d;
        end
    end

    assign resu = resu_q;
endmodule

// File: tb/tb_fa_multiss.sv
// Self-checking bench for fa_multiss: a vector table, corner sequences, and an exhaustive sweep.
module tb_fa_multiss;
    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic [W-1:0]   mulcado;
    logic [W-1:0]   multi;
    logic [2*W-1:0] resu;

    int errors = 0;
    int checks = 0;

    logic [2*W-1:0] exp_q[$];
    string          name_q[$];

    typedef struct {
        logic           r;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        string          nm;
    } vec_t;

    vec_t vecs[15];

    fa_multiss #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .mulcado (mulcado),
        .multi   (multi),
        .resu    (resu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: resu=%h expected %h", nm, got, want);
        end
    endtask

    // Drive the inputs on the falling edge, queue the expectation, and check it just after the rising edge.
    task automatic apply(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string nm);
        logic [2*W-1:0] e;
        string          n;
        @(negedge clk);
        rst     = r;
        mulcado = a;
        multi   = b;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: resu=%h expected a queued value", resu);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compare(n, resu, e);
        end
    endtask

    initial begin
        logic [2*W-1:0] m;

        rst     = 1'b1;
        mulcado = '0;
        multi   = '0;

        vecs[0]  = '{1'b1, 4'hF, 4'hF, 8'h00, "reset_edge1"};
        vecs[1]  = '{1'b1, 4'hF, 4'hF, 8'h00, "reset_edge2"};
        vecs[2]  = '{1'b0, 4'h6, 4'h9, 8'h36, "6x9"};
        vecs[3]  = '{1'b0, 4'h0, 4'hF, 8'h00, "0xF"};
        vecs[4]  = '{1'b0, 4'hF, 4'h0, 8'h00, "Fx0"};
        vecs[5]  = '{1'b0, 4'h1, 4'hB, 8'h0B, "1xB"};
        vecs[6]  = '{1'b0, 4'hF, 4'hF, 8'hE1, "FxF"};
        vecs[7]  = '{1'b0, 4'h8, 4'h8, 8'h40, "8x8"};
        vecs[8]  = '{1'b0, 4'h3, 4'h5, 8'h0F, "b2b_3x5"};
        vecs[9]  = '{1'b0, 4'h7, 4'h7, 8'h31, "b2b_7x7"};
        vecs[10] = '{1'b0, 4'hC, 4'hA, 8'h78, "b2b_12x10"};
        vecs[11] = '{1'b1, 4'h9, 4'h9, 8'h00, "midreset_9x9"};
        vecs[12] = '{1'b0, 4'h9, 4'h9, 8'h51, "after_reset_9x9"};
        vecs[13] = '{1'b0, 4'hA, 4'h5, 8'h32, "Ax5"};
        vecs[14] = '{1'b0, 4'h5, 4'hA, 8'h32, "5xA"};

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);
        end

        // A change of operands between edges must not reach resu before the next edge.
        apply(1'b0, 4'h3, 4'h5, 8'h0F, "hold_base");
        mulcado = 4'hA;
        multi   = 4'hA;
        #3;
        compare("hold_midcycle", resu, 8'h0F);
        apply(1'b0, 4'hA, 4'hA, 8'h64, "hold_next_edge");

        // A reset asserted in the middle of a run wins over the operands, then products resume.
        apply(1'b0, 4'hE, 4'hD, 8'hB6, "run_ExD");
        apply(1'b1, 4'hE, 4'hD, 8'h00, "reset_over_ExD");
        apply(1'b0, 4'h2, 4'h7, 8'h0E, "resume_2x7");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                m = 8'(a) * 8'(b);
                apply(1'b0, 4'(a), 4'(b), m, $sformatf("sweep_%0dx%0d", a, b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
